// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: operand widths, operand RAM map and
// the exp_prep controller state encoding.
package rsa_pkg;

  localparam int BITLEN     = 256;
  localparam int LOG_BITLEN = 8;

  // Operand RAM locations consumed by the Montgomery exponentiator
  localparam int ADDR_XBAR  = 0;
  localparam int ADDR_MBAR  = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FIND = 3'd1,
    XBAR = 3'd2,
    XWR  = 3'd3,
    MBAR = 3'd4,
    MWR  = 3'd5,
    GO   = 3'd6,
    ERR  = 3'd7
  } prep_state_t;

endpackage

// File: rtl/mod_double.sv
// Modular doubling: r2 = (2*r) mod n, valid for r < n.
// One extra bit of width keeps 2*r exact even when n is close to 2^W.
module mod_double #(
  parameter int W = 256
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] n,
  output logic [W-1:0] r2
);

  logic [W:0] dbl;
  logic [W:0] diff;

  // Double, then subtract n once if the doubled value reached n
  always_comb begin
    dbl  = {r, 1'b0};
    diff = dbl - {1'b0, n};
    r2   = (dbl >= {1'b0, n}) ? diff[W-1:0] : dbl[W-1:0];
  end

endmodule

// File: rtl/exp_prep.sv
// Montgomery operand preparation: computes R mod n and M*R mod n (R = 2^k,
// k = bit length of n), writes them to the operand RAM, reports the exponent
// MSB index and k, then pulses exp_start.
// Optional feature macro: EXP_PREP_CHECK_EN enables operand validity checks
// and the ERR completion path; without it err is constant 0.
module exp_prep #(
  parameter int BITLEN     = rsa_pkg::BITLEN,
  parameter int LOG_BITLEN = rsa_pkg::LOG_BITLEN,
  parameter int ABITS      = 8,
  parameter int DBITS      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BITLEN-1:0]     m,
  input  logic [BITLEN-1:0]     e,
  input  logic [BITLEN-1:0]     n,
  output logic [ABITS-1:0]      wr_addr,
  output logic [DBITS-1:0]      wr_data,
  output logic                  wr_en,
  output logic [LOG_BITLEN-1:0] e_idx,
  output logic [LOG_BITLEN:0]   mp_count,
  output logic                  exp_start,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  import rsa_pkg::*;

  prep_state_t           state_q, state_d;
  logic [BITLEN-1:0]     m_q, e_q, n_q;
  logic [BITLEN-1:0]     r_q, r_dbl;
  logic [LOG_BITLEN:0]   cnt_q;
  logic [LOG_BITLEN-1:0] e_msb, n_msb;
  logic [LOG_BITLEN:0]   k;
  logic                  accept;

  assign accept = (state_q == IDLE) && start;
  assign busy   = (state_q != IDLE);

  mod_double #(.W(BITLEN)) u_mod_double (
    .r  (r_q),
    .n  (n_q),
    .r2 (r_dbl)
  );

  // Priority encoders: highest set bit of the latched exponent and modulus
  always_comb begin
    e_msb = '0;
    n_msb = '0;
    for (int i = 0; i < BITLEN; i++) begin
      if (e_q[i]) e_msb = LOG_BITLEN'(i);
      if (n_q[i]) n_msb = LOG_BITLEN'(i);
    end
  end

  assign k = {1'b0, n_msb} + 1'b1;

`ifdef EXP_PREP_CHECK_EN
  logic op_err;

  // Operand validity: odd modulus >= 3, non-zero exponent, plaintext below n
  always_comb begin
    op_err = ~n_q[0] | (n_q < BITLEN'(3)) | (e_q == '0) | (m_q >= n_q);
  end
`endif

  // State register
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and Moore outputs; RAM port is forced to zero between writes
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    exp_start = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = FIND;
`ifdef EXP_PREP_CHECK_EN
      FIND: state_d = op_err ? ERR : XBAR;
`else
      FIND: state_d = XBAR;
`endif
      XBAR: if (cnt_q == 1) state_d = XWR;
      XWR: begin
        wr_en   = 1'b1;
        wr_addr = ABITS'(ADDR_XBAR);
        wr_data = DBITS'(r_q);
        state_d = MBAR;
      end
      MBAR: if (cnt_q == 1) state_d = MWR;
      MWR: begin
        wr_en   = 1'b1;
        wr_addr = ABITS'(ADDR_MBAR);
        wr_data = DBITS'(r_q);
        state_d = GO;
      end
      GO: begin
        exp_start = 1'b1;
        done      = 1'b1;
        state_d   = IDLE;
      end
`ifdef EXP_PREP_CHECK_EN
      ERR: begin
        done    = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Operand latches and the doubling accumulator/iteration counter
  // NOTE: these wide data registers carry no reset; their contents are
  // don't-care until loaded by start acceptance or FIND.
  always_ff @(posedge clk) begin
    if (accept) begin
      m_q <= m;
      e_q <= e;
      n_q <= n;
    end
    if (state_q == FIND) begin
      r_q   <= BITLEN'(1);
      cnt_q <= k;
    end else if (state_q == XWR) begin
      r_q   <= m_q;
      cnt_q <= k;
    end else if (state_q == XBAR || state_q == MBAR) begin
      r_q   <= r_dbl;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Result registers, loaded in FIND and held until the next job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_idx    <= '0;
      mp_count <= '0;
    end else if (state_q == FIND) begin
      e_idx    <= e_msb;
      mp_count <= k;
    end
  end

`ifdef EXP_PREP_CHECK_EN
  // Error flag: cleared on acceptance, set in FIND when operands are invalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err <= 1'b0;
    else if (accept)           err <= 1'b0;
    else if (state_q == FIND)  err <= op_err;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_exp_prep.sv
// Self-checking bench for exp_prep: table of operand sets with expected
// Montgomery operands, plus start-ignore, mid-job reset and back-to-back cases.
module tb_exp_prep;

  localparam int BL = 256;
  localparam int LB = 8;
  localparam int AB = 8;
  localparam int DB = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [BL-1:0] m = '0, e = '0, n = '0;
  logic [AB-1:0] wr_addr;
  logic [DB-1:0] wr_data;
  logic          wr_en;
  logic [LB-1:0] e_idx;
  logic [LB:0]   mp_count;
  logic          exp_start, busy, done, err;

  always #5 clk = ~clk;

  exp_prep #(.BITLEN(BL), .LOG_BITLEN(LB), .ABITS(AB), .DBITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m(m), .e(e), .n(n),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .e_idx(e_idx),
    .mp_count(mp_count), .exp_start(exp_start), .busy(busy), .done(done),
    .err(err)
  );

  typedef struct {
    logic [BL-1:0] m, e, n;
    logic [LB-1:0] e_idx;
    logic [LB:0]   k;
    logic [BL-1:0] xbar, mbar;
    logic          err;
    int            lat;
  } vec_t;

  vec_t          vecs[$];
  vec_t          sb[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            wr_count = 0;
  int            exp_cnt = 0;
  int            bad_idle = 0;
  int            cyc;
  logic [BL-1:0] ram[2];

  task automatic check(input string name, input logic [BL-1:0] act, input logic [BL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [BL-1:0] mi, ei, ni, input int eidx, kk,
                              input logic [BL-1:0] xb, mb, input logic er, input int lat);
    vec_t v;
    v.m = mi; v.e = ei; v.n = ni;
    v.e_idx = LB'(eidx); v.k = (LB+1)'(kk);
    v.xbar = xb; v.mbar = mb; v.err = er; v.lat = lat;
    return v;
  endfunction

  // RAM model and port hygiene monitor
  always @(negedge clk) begin
    if (wr_en) begin
      wr_count++;
      if (wr_addr < 2) ram[wr_addr[0]] = wr_data;
      else bad_idle++;
    end else if (wr_addr != '0 || wr_data != '0) begin
      bad_idle++;
    end
    if (exp_start) exp_cnt++;
  end

  // Entered at posedge+#1; returns at posedge+#1 of the cycle after done
  task automatic do_job(input vec_t v, input int inject_cyc, input vec_t alt);
    vec_t x;
    sb.push_back(v);
    wr_count = 0; exp_cnt = 0; ram[0] = '0; ram[1] = '0;
    m = v.m; e = v.e; n = v.n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; m = ~v.m; e = '0; n = '0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("busy_rise", busy, 1);
      if (cyc == inject_cyc) begin
        start = 1'b1; m = alt.m; e = alt.e; n = alt.n;
      end else begin
        start = 1'b0;
      end
    end while (!done && cyc < 600);
    check("done_seen", done, 1);
    x = sb.pop_front();
    check("latency", cyc, x.lat);
    check("err_with_done", err, x.err);
    @(posedge clk); #1;
    check("busy_after", busy, 0);
    check("exp_start_cnt", exp_cnt, x.err ? 0 : 1);
    check("wr_count", wr_count, x.err ? 0 : 2);
    check("err_held", err, x.err);
    if (!x.err) begin
      check("e_idx", e_idx, x.e_idx);
      check("mp_count", mp_count, x.k);
      check("ram_xbar", ram[0], x.xbar);
      check("ram_mbar", ram[1], x.mbar);
    end
  endtask

  initial begin
    vec_t alt;
    // n=13/m=5 followed directly by n=11/m=4 exercises back-to-back jobs
    vecs.push_back(mk(5, 4'b1011, 13, 3, 4, 3, 2, 1'b0, 12));
    vecs.push_back(mk(4, 8'h10, 11, 4, 4, 5, 9, 1'b0, 12));
    vecs.push_back(mk(2, 1, {BL{1'b1}}, 0, 256, 1, 2, 1'b0, 516));
    vecs.push_back(mk(3, 8'h80, 7, 7, 3, 1, 3, 1'b0, 10));
    vecs.push_back(mk(100, {1'b1, {(BL-1){1'b0}}}, 255, 255, 8, 1, 100, 1'b0, 20));
    vecs.push_back(mk(2, 3, 3, 1, 2, 1, 2, 1'b0, 8));
`ifdef EXP_PREP_CHECK_EN
    vecs.push_back(mk(5, 1, 12, 0, 0, 0, 0, 1'b1, 2));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1'b1, 2));
    vecs.push_back(mk(5, 0, 13, 0, 0, 0, 0, 1'b1, 2));
    vecs.push_back(mk(13, 1, 13, 0, 0, 0, 0, 1'b1, 2));
`endif
    alt = mk(4, 8'h10, 11, 4, 4, 5, 9, 1'b0, 12);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_e_idx", e_idx, 0);
    check("rst_mp_count", mp_count, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table, run back-to-back
    foreach (vecs[i]) do_job(vecs[i], 0, alt);

    // start re-asserted during XBAR with other operands is ignored
    do_job(vecs[0], 3, alt);

    // Reset pulse during MBAR
    wr_count = 0; exp_cnt = 0;
    m = vecs[0].m; e = vecs[0].e; n = vecs[0].n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_wr_en", wr_en, 0);
    check("ar_wr_addr", wr_addr, 0);
    check("ar_wr_data", wr_data, 0);
    check("ar_exp_start", exp_start, 0);
    check("ar_e_idx", e_idx, 0);
    check("ar_mp_count", mp_count, 0);
    check("ar_err", err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("ar_wr_count", wr_count, 1);
    check("ar_exp_cnt", exp_cnt, 0);
    @(posedge clk); #1;
    do_job(vecs[0], 0, alt);

    check("port_zero_when_idle", bad_idle, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
